// File: rtl/iwtu_lvl_1.sv
// -----------------------------------------------------------------------------
// iwtu_lvl_1 -- one level of the inverse integer S-transform (Haar lifting).
//
// Takes a coefficient pair {hs, ls} and reconstructs two samples:
//   b = ls - (hs >>> 1)     (arithmetic shift, i.e. floor(hs/2))
//   a = hs + b
// All arithmetic wraps modulo 2^W. Sample a is emitted first (out_sel=0),
// then sample b (out_sel=1).
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid=1 and ready=1. The producer holds valid and data stable until
// that edge; ready may be asserted with or without valid and has no effect
// on its own.
//
// Ports:
//   clk       in   clock, all state updates on rising edge
//   rst       in   asynchronous, active-low reset
//   in        in   [2W-1:0] coefficient pair, hs = in[2W-1:W], ls = in[W-1:0]
//   in_vld    in   in holds a valid pair
//   in_rdy    out  block can accept a pair (high exactly in IDLE)
//   out       out  [W-1:0] reconstructed sample
//   out_vld   out  out holds a valid sample (SEND_A / SEND_B)
//   out_rdy   in   downstream accepts out this cycle
//   out_sel   out  0 = sample a, 1 = sample b
//   pair_cnt  out  [15:0] number of fully emitted pairs, wraps silently
//
// The FSM state is kept in the typed signal 'state' so checkers can bind
// to it directly.
// -----------------------------------------------------------------------------
module iwtu_lvl_1 #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*W-1:0] in,
    input  logic           in_vld,
    output logic           in_rdy,
    output logic [W-1:0]   out,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic           out_sel,
    output logic [15:0]    pair_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        SEND_A = 2'd2,
        SEND_B = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [W-1:0] hs_q;
    logic [W-1:0] ls_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    logic [W-1:0] hs_half;
    logic [W-1:0] b_calc;
    logic [W-1:0] a_calc;

    logic         accept;
    logic         a_done;
    logic         b_done;

    // Arithmetic shift right by one: replicate the sign bit.
    assign hs_half = {hs_q[W-1], hs_q[W-1:1]};
    assign b_calc  = ls_q - hs_half;
    assign a_calc  = hs_q + b_calc;

    // out follows out_sel between the two result registers. Both registers
    // and out_sel only change at the CALC edge and the a-accept edge, so out
    // keeps its last driven value through IDLE/CALC and is stable during a
    // stall without needing its own register.
    assign out = out_sel ? b_q : a_q;

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        accept    = 1'b0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = SEND_A;
            end
            SEND_A: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    a_done    = 1'b1;
                    state_nxt = SEND_B;
                end
            end
            SEND_B: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    b_done    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q     <= '0;
            ls_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_sel  <= 1'b0;
            pair_cnt <= 16'd0;
        end else begin
            if (accept) begin
                hs_q <= in[2*W-1:W];
                ls_q <= in[W-1:0];
            end
            if (state == CALC) begin
                a_q     <= a_calc;
                b_q     <= b_calc;
                out_sel <= 1'b0;
            end
            if (a_done) begin
                out_sel <= 1'b1;
            end
            if (b_done) begin
                pair_cnt <= pair_cnt + 16'd1;
            end
        end
    end

endmodule
